instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/pc_next.sv | 32 +++
 rtl/instr_fetch.sv | 90 +++++++++
 tb/tb_instr_fetch.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU encodings: PC-select codes and fetch FSM states.
// Used by the instruction-fetch block and the controller.
package cpu_pkg;

  typedef enum logic [1:0] {
    PC_SEQ  = 2'b00,
    PC_BR   = 2'b01,
    PC_JMP  = 2'b10,
    PC_HALT = 2'b11
  } pc_sel_e;

  typedef enum logic [1:0] {
    S_FETCH = 2'b00,
    S_EXEC  = 2'b01,
    S_HALT  = 2'b10
  } fetch_state_e;

  localparam int BR_OFF_W = 11;

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC selection: sequential, relative branch, absolute jump or hold.
// All arithmetic wraps modulo 2^PC_W.
module pc_next
  import cpu_pkg::*;
#(
  parameter int PC_W = 16
) (
  input  logic [PC_W-1:0]     pc,
  input  logic [BR_OFF_W-1:0] offset,
  input  logic [PC_W-1:0]     jmp_target,
  input  pc_sel_e             sel,
  output logic [PC_W-1:0]     next_pc
);

  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] off_ext;

  assign pc_inc  = pc + PC_W'(1);
  assign off_ext = {{(PC_W-BR_OFF_W){offset[BR_OFF_W-1]}}, offset};

  always_comb begin
    next_pc = pc;
    unique case (sel)
      PC_SEQ:  next_pc = pc_inc;
      PC_BR:   next_pc = pc_inc + off_ext;
      PC_JMP:  next_pc = jmp_target;
      PC_HALT: next_pc = pc;
      default: next_pc = pc;
    endcase
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: FETCH/EXEC/HALT FSM owning PC, IR and the retired-instruction counter.
// One instruction is fetched, then held in EXEC until the datapath releases it.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [15:0]     imem_rdata,
  output logic [15:0]     IR,
  output logic            ir_valid,
  input  logic [1:0]      choosePCUpdate,
  input  logic [PC_W-1:0] jmp_target,
  input  logic            ex_stall,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus1,
  output logic            halted,
  output logic [15:0]     retired
);

  fetch_state_e    state, state_nxt;
  logic            pc_en, ir_en, ret_en;
  logic [PC_W-1:0] nxt_pc;
  pc_sel_e         sel;

  assign sel       = pc_sel_e'(choosePCUpdate);
  assign imem_addr = pc;
  assign pc_plus1  = pc + PC_W'(1);

  pc_next #(.PC_W(PC_W)) u_pc_next (
    .pc        (pc),
    .offset    (IR[BR_OFF_W-1:0]),
    .jmp_target(jmp_target),
    .sel       (sel),
    .next_pc   (nxt_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    ir_valid  = 1'b0;
    halted    = 1'b0;
    pc_en     = 1'b0;
    ir_en     = 1'b0;
    ret_en    = 1'b0;
    unique case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_en     = 1'b1;
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        ir_valid = 1'b1;
        // A stalled EXEC ignores the select entirely; it is sampled on release.
        if (!ex_stall) begin
          pc_en     = 1'b1;
          ret_en    = 1'b1;
          state_nxt = (sel == PC_HALT) ? S_HALT : S_FETCH;
        end
      end
      S_HALT:  halted = 1'b1;
      default: state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_PC;
      IR      <= '0;
      retired <= '0;
    end else begin
      if (pc_en) pc <= nxt_pc;
      if (ir_en) IR <= imem_rdata;
      if (ret_en && retired != 16'hFFFF) retired <= retired + 16'd1;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: the stimulus pushes the expected per-cycle view,
// and a negedge monitor pops and compares it against what the DUT presents.
module tb_instr_fetch;

  localparam logic [2:0] KF = 3'b001;  // {halted, ir_valid, imem_req}
  localparam logic [2:0] KE = 3'b010;
  localparam logic [2:0] KH = 3'b100;

  typedef struct {
    logic [2:0]  kind;
    logic [15:0] pc;
    logic [15:0] ir;
    logic [15:0] ret;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_rdata;
  logic [15:0] IR;
  logic        ir_valid;
  logic [1:0]  choosePCUpdate;
  logic [15:0] jmp_target;
  logic        ex_stall;
  logic [15:0] pc;
  logic [15:0] pc_plus1;
  logic        halted;
  logic [15:0] retired;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  bit   mon_en = 1'b0;
  int   cyc = 0;

  instr_fetch #(.PC_W(16), .RESET_PC(16'h0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .IR            (IR),
    .ir_valid      (ir_valid),
    .choosePCUpdate(choosePCUpdate),
    .jmp_target    (jmp_target),
    .ex_stall      (ex_stall),
    .pc            (pc),
    .pc_plus1      (pc_plus1),
    .halted        (halted),
    .retired       (retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL scoreboard_empty cycle %0d: got output with no expectation", cyc);
      end else begin
        e = q.pop_front();
        chk("state_kind", {13'd0, halted, ir_valid, imem_req}, {13'd0, e.kind});
        chk("pc", pc, e.pc);
        chk("pc_plus1", pc_plus1, e.pc + 16'd1);
        chk("IR", IR, e.ir);
        chk("retired", retired, e.ret);
        if (e.kind == KF) chk("imem_addr", imem_addr, e.pc);
      end
    end
  end

  // One cycle: record what the DUT should show now, drive inputs for the next edge.
  task automatic step(input logic [2:0] k, input logic [15:0] epc, input logic [15:0] eir,
                      input logic [15:0] eret, input logic rs, input logic rdy,
                      input logic [15:0] rd, input logic [1:0] sel, input logic st,
                      input logic [15:0] jt);
    exp_t e;
    e.kind = k; e.pc = epc; e.ir = eir; e.ret = eret;
    q.push_back(e);
    rst = rs; imem_ready = rdy; imem_rdata = rd;
    choosePCUpdate = sel; ex_stall = st; jmp_target = jt;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    rst = 1'b1; imem_ready = 1'b0; imem_rdata = '0;
    choosePCUpdate = 2'b00; ex_stall = 1'b0; jmp_target = '0;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    //    kind pc        IR        ret  rst  rdy  rdata     sel    stall jt
    step(KF, 16'h0000, 16'h0000, 16'd0,  0, 1, 16'h0800, 2'd0, 0, 16'h0000);
    step(KE, 16'h0000, 16'h0800, 16'd0,  0, 0, 16'h0000, 2'd0, 0, 16'h0000);
    step(KF, 16'h0001, 16'h0800, 16'd1,  0, 1, 16'h0800, 2'd0, 0, 16'h0000);
    step(KE, 16'h0001, 16'h0800, 16'd1,  0, 0, 16'h0000, 2'd0, 0, 16'h0000);
    step(KF, 16'h0002, 16'h0800, 16'd2,  0, 1, 16'h0800, 2'd0, 0, 16'h0000);
    step(KE, 16'h0002, 16'h0800, 16'd2,  0, 0, 16'h0000, 2'd0, 0, 16'h0000);
    step(KF, 16'h0003, 16'h0800, 16'd3,  0, 1, 16'h1111, 2'd0, 0, 16'h0000);
    step(KE, 16'h0003, 16'h1111, 16'd3,  0, 0, 16'h0000, 2'd0, 0, 16'h0000);
    step(KF, 16'h0004, 16'h1111, 16'd4,  0, 1, 16'h2222, 2'd0, 0, 16'h0000);
    step(KE, 16'h0004, 16'h2222, 16'd4,  0, 0, 16'h0000, 2'd0, 0, 16'h0000);
    // memory answers only on the fourth request cycle at pc 5
    step(KF, 16'h0005, 16'h2222, 16'd5,  0, 0, 16'h0000, 2'd0, 0, 16'h0000);
    step(KF, 16'h0005, 16'h2222, 16'd5,  0, 0, 16'h0000, 2'd0, 0, 16'h0000);
    step(KF, 16'h0005, 16'h2222, 16'd5,  0, 0, 16'hBEEF, 2'd0, 0, 16'h0000);
    step(KF, 16'h0005, 16'h2222, 16'd5,  0, 1, 16'hABCD, 2'd0, 0, 16'h0000);
    step(KE, 16'h0005, 16'hABCD, 16'd5,  0, 1, 16'hFFFF, 2'd2, 0, 16'h0010);
    // relative branches: -2 from 0x10, +1023 from 0x0F
    step(KF, 16'h0010, 16'hABCD, 16'd6,  0, 1, 16'h8FFE, 2'd0, 0, 16'h0000);
    step(KE, 16'h0010, 16'h8FFE, 16'd6,  0, 0, 16'h0000, 2'd1, 0, 16'h0000);
    step(KF, 16'h000F, 16'h8FFE, 16'd7,  0, 1, 16'h03FF, 2'd0, 0, 16'h0000);
    step(KE, 16'h000F, 16'h03FF, 16'd7,  0, 0, 16'h0000, 2'd1, 0, 16'h0000);
    step(KF, 16'h040F, 16'h03FF, 16'd8,  0, 1, 16'h0000, 2'd0, 0, 16'h0000);
    step(KE, 16'h040F, 16'h0000, 16'd8,  0, 0, 16'h0000, 2'd2, 0, 16'hFFFF);
    // sequential wrap at 0xFFFF, then a negative branch wrapping below zero
    step(KF, 16'hFFFF, 16'h0000, 16'd9,  0, 1, 16'h0001, 2'd0, 0, 16'h0000);
    step(KE, 16'hFFFF, 16'h0001, 16'd9,  0, 0, 16'h0000, 2'd0, 0, 16'h0000);
    step(KF, 16'h0000, 16'h0001, 16'd10, 0, 1, 16'h07FE, 2'd0, 0, 16'h0000);
    step(KE, 16'h0000, 16'h07FE, 16'd10, 0, 0, 16'h0000, 2'd1, 0, 16'h0000);
    // jump held by a two-cycle stall; halt select during stall must be ignored
    step(KF, 16'hFFFF, 16'h07FE, 16'd11, 0, 1, 16'h5555, 2'd0, 0, 16'h0000);
    step(KE, 16'hFFFF, 16'h5555, 16'd11, 0, 0, 16'h0000, 2'd2, 1, 16'h1234);
    step(KE, 16'hFFFF, 16'h5555, 16'd11, 0, 0, 16'h0000, 2'd3, 1, 16'h1234);
    step(KE, 16'hFFFF, 16'h5555, 16'd11, 0, 0, 16'h0000, 2'd2, 0, 16'h1234);
    step(KF, 16'h1234, 16'h5555, 16'd12, 0, 1, 16'h0000, 2'd0, 0, 16'h0000);
    step(KE, 16'h1234, 16'h0000, 16'd12, 0, 0, 16'h0000, 2'd3, 0, 16'h0000);
    // halted: ready/data and selects have no effect
    step(KH, 16'h1234, 16'h0000, 16'd13, 0, 1, 16'hFFFF, 2'd0, 0, 16'h0000);
    step(KH, 16'h1234, 16'h0000, 16'd13, 0, 1, 16'hFFFF, 2'd2, 0, 16'h0000);
    step(KH, 16'h1234, 16'h0000, 16'd13, 1, 0, 16'h0000, 2'd0, 0, 16'h0000);
    // reset still high while memory answers mid-FETCH: data is discarded
    step(KF, 16'h0000, 16'h0000, 16'd0,  1, 1, 16'h9999, 2'd0, 0, 16'h0000);
    step(KF, 16'h0000, 16'h0000, 16'd0,  0, 1, 16'h0042, 2'd0, 0, 16'h0000);
    step(KE, 16'h0000, 16'h0042, 16'd0,  0, 0, 16'h0000, 2'd0, 0, 16'h0000);
    step(KF, 16'h0001, 16'h0042, 16'd1,  0, 0, 16'h0000, 2'd0, 0, 16'h0000);
    mon_en = 1'b0;
    chk("scoreboard_drained", 16'(q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
